serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences one full_adder cell (1-bit a/b/c in, sum/carry out) over WIDTH cycles to add two WIDTH-bit operands. It uses a start/busy/done handshake: load on start, process one bit per clock LSB-first, then present the registered result with a one-cycle done pulse. It is the area-minimal alternative to a ripple-carry array and sits between an operand source and a result consumer.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in; captured on accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  registered result; held until the next accepted start.
cout  output  1  registered final carry; held with sum.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and counter are all 0.
  - rst wins over every other input in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: a_sh<=a, b_sh<=b, c_reg<=cin, cnt<=0, sum<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (one bit per edge):
  - The full_adder instance is driven with a_sh[0], b_sh[0], c_reg.
  - a_sh and b_sh shift right one place.
  - sum shifts right, and the FA sum enters at bit WIDTH-1.
  - c_reg<=FA carry; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge: that is the last bit. Also cout<=FA carry; go to DONE.
- DONE: done=1 for exactly this cycle; the next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0.
  - Bits are processed at edges E1..E_WIDTH.
  - done is high in the cycle following edge E_WIDTH.
  - The next start can be accepted at edge E_(WIDTH+2).
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No saturation.
- start while busy (RUN or DONE): ignored. The operation in flight and the latched operands are unaffected.
- a, b, cin may change freely after the accept edge.
- Reset mid-operation: returns to IDLE with outputs zeroed. The partial result is discarded and no done pulse is issued.
- sum/cout during RUN: intermediate and invalid. Consumers qualify with done, or sample while busy=0 after a done.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - At the final RUN edge: ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). This is two's-complement signed overflow.
  - ovf is held with sum, and is reset to 0 by rst and on an accepted start.
- Undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- WIDTH=8: a=0x35, b=0x4A, cin=0, start for 1 cycle -> busy high for 9 cycles, done pulse 9 cycles after the accept edge, sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Issued back-to-back at the earliest legal start.
- Start 0x10+0x20; pulse start with a=0xAA, b=0x55 during RUN bit 3 -> the second start is ignored, result sum=0x30, cout=0, exactly one done.
- Reset mid-op: assert rst at RUN bit 4 of 0xF0+0x0F -> next cycle busy=0, sum=0, no done. A new op 0x01+0x01 -> sum=0x02.
- SERIAL_ADDER_OVF_EN defined:
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
  - 0x05+0x03 -> ovf=0.
- Hold start=1 continuously for 30 cycles, a=0x01, b=0x02 -> ops accepted every 10 cycles, each done with sum=0x03; done never high for two consecutive cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell stepped LSB-first over WIDTH clocks behind a start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (c_reg),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state == S_RUN) || (state == S_DONE);
  assign done     = (state == S_DONE);

  // The result register doubles as the output shift register: each new sum bit
  // enters at the MSB, so after WIDTH steps bit 0 has walked down into place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          sum   <= {fa_s, sum[WIDTH-1:1]};
          c_reg <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // c_reg holds the carry into the MSB on the final step
            ovf   <= c_reg ^ fa_c;
`endif
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, hand sequences for
// handshake corner cases, and randomized operations against an arithmetic reference model.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    checkOutput({tag, " sum"}, 32'(sum), 32'(es));
    checkOutput({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] note: %s overflow expectation unknown", tag);
`endif
  endtask

  // Reference: plain unsigned addition for {cout,sum}, signed range test for overflow
  function automatic void refModel(input logic [7:0] x, input logic [7:0] y, input logic ci,
                                   output logic [7:0] s, output logic co, output logic ov);
    int us;
    int ss;
    us = int'(x) + int'(y) + int'(ci);
    s  = 8'(us % 256);
    co = (us >= 256);
    ss = int'($signed(x)) + int'($signed(y)) + int'(ci);
    ov = (ss > 127) || (ss < -128);
  endfunction

  // mode 0: quiet; mode 1: random start noise while busy; mode 2: one AA+55 start pulse at RUN bit 3
  task automatic applyStimulus(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic ci, input logic [7:0] es, input logic ec,
                               input logic eo, input int mode);
    int doneAt;
    int doneCnt;
    int busyCnt;
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = ci;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    doneAt = -1; doneCnt = 0; busyCnt = 0;
    for (int i = 1; i <= W + 4; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
        checkResult({tag, " at done"}, es, ec, eo);
      end
      if (mode == 1 && i <= W + 1) begin
        start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else if (mode == 2 && i == 4) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(W + 1));
    checkOutput({tag, " done count"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(W + 1));
    checkResult({tag, " held"}, es, ec, eo);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic       ro;
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rci;
    int         dcount;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[9] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkResult("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].sum, vecs[i].cout, vecs[i].ovf, 0);

    applyStimulus("start during run", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 2);

    // Back-to-back: start held high so the second op lands on the earliest legal edge
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("b2b first done", 32'(done), 32'd1);
    checkResult("b2b first", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("b2b gap busy", 32'(busy), 32'd0);
    checkOutput("b2b gap done", 32'(done), 32'd0);
    checkResult("b2b gap held", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b second busy", 32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("b2b second done", 32'(done), 32'd1);
    checkResult("b2b second", 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("b2b second pulse end", 32'(done), 32'd0);

    // Reset in the middle of an operation discards it without a done pulse
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkResult("midreset", 8'h00, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checkOutput("midreset no done", 32'(dcount), 32'd0);
    applyStimulus("after reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // start held for 30 cycles: accepts every W+2 cycles, done pulses never adjacent
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    dcount = 0;
    for (int j = 1; j <= 42; j++) begin
      @(negedge clk);
      if (j == 29) start = 1'b0;
      checkOutput($sformatf("held start done@%0d", j), 32'(done),
                  32'(((j % (W + 2)) == W + 1) && (j < 30)));
      if (done) begin
        dcount++;
        checkResult("held start", 8'h03, 1'b0, 1'b0);
      end
    end
    checkOutput("held start op count", 32'(dcount), 32'd3);

    for (int k = 0; k < 30; k++) begin
      rx = 8'($urandom); ry = 8'($urandom); rci = 1'($urandom);
      refModel(rx, ry, rci, rs, rc, ro);
      applyStimulus($sformatf("rand%0d %0h+%0h+%0b", k, rx, ry, rci), rx, ry, rci, rs, rc, ro, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
